uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver and successor to the fixed 8N1 receiver. Supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits. Applies 3-sample majority voting around mid-bit, rejects start-bit glitches, and reports parity and framing errors alongside each received word. Sits between the board-level rx pin and any byte consumer (command decoder, FIFO).

Parameters:
CLK_FRE, 50_000_000, system clock frequency in Hz
BAUD, 9600, line baud rate
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx  input  1  asynchronous serial line, idle high
data  output  DATA_BITS  last received word, LSB = first data bit
data_flag  output  1  one-cycle pulse: data/parity_err/frame_err updated
parity_err  output  1  parity mismatch on last word (always 0 when PARITY = 0)
frame_err  output  1  at least one stop bit sampled low on last word
busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Derived constants: BAUD_CNT_MAX = CLK_FRE/BAUD and MID = BAUD_CNT_MAX/2. The baud counter width is $clog2(BAUD_CNT_MAX).
- Elaboration-time check: BAUD_CNT_MAX >= 8, DATA_BITS in 5..9, PARITY <= 2, STOP_BITS in 1..2. An illegal value is a fatal elaboration error.
- Clock and reset: single clock clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0. data = 0. Synchronizer flops = 1. FSM = IDLE.
- Synchronizer: rx passes through 3 flops (s1, s2, s3). A falling edge is s2 == 0 && s3 == 1. The FSM uses s2 as the line value.
- Sampling: in every bit, the line is sampled at baud_cnt == MID-1, MID and MID+1. The bit value is the majority of the 3 samples, resolved at MID+1.
- The baud counter runs 0..BAUD_CNT_MAX-1 while not in IDLE, wraps to 0, and is held at 0 in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a falling edge, go to START with baud_cnt = 0 and busy = 1 on the next cycle.
  - START: if the majority at MID+1 is 1, it is a glitch; return to IDLE with no flag. Otherwise go to DATA at wrap.
  - DATA: shift the majority bit in LSB-first. After DATA_BITS bits, go to PARITY at wrap (or to STOP when PARITY = 0).
  - PARITY: compare against the XOR of the data bits. Odd parity expects the total count of 1s, parity bit included, to be odd; even parity expects it to be even.
  - STOP: each stop bit is majority-sampled; any 0 sets frame_err. On the final stop bit, the frame completes at the MID+1 resolve cycle, not at wrap. The FSM goes to IDLE the next cycle so that a start bit immediately following is caught.
- Completion: in the cycle after the final stop-bit resolve, data, parity_err and frame_err update, and data_flag is high for exactly 1 cycle. busy drops in the same cycle.
- data and the error flags hold their values until the next completion.
- Words with errors are still delivered: data is valid, with the flag(s) set.
- A falling edge while the FSM is not in IDLE is ignored.
- A line held low (break) produces frame_err = 1 with data = 0. The receiver then waits in IDLE for a rising edge followed by a fresh falling edge.
- Reset mid-frame aborts immediately. The partial word is discarded and no data_flag is issued.

Decomposition:
- Package uart_pkg holds:
  - parity encodings PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2;
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - a function computing BAUD_CNT_MAX from CLK_FRE and BAUD.
- One sub-module, uart_rx_sync: the 3-flop synchronizer with falling-edge detect. It is reusable by a future auto-baud block.
- The FSM, counters and shift register stay in uart_rx_cfg.

Test Plan:
- Base config: CLK_FRE = 50_000_000, BAUD = 115200 (BAUD_CNT_MAX = 434). Default parameters, frame 0xA5 -> data = 0xA5, data_flag high exactly 1 cycle, parity_err = 0, frame_err = 0, busy low afterwards.
- PARITY = 2, frame 0x3C with parity bit 1 (wrong; correct is 0) -> data = 0x3C, parity_err = 1. Next frame 0x3C with parity bit 0 -> parity_err = 0.
- Start glitch: rx low for 100 cycles, then high -> no data_flag; busy returns to 0 by 434 cycles. A following 0x5A frame is received correctly.
- Framing: frame 0x81 with stop bit driven low -> data = 0x81, frame_err = 1. With STOP_BITS = 2 and only the second stop bit low -> frame_err = 1.
- Back-to-back: 0x55 then 0xAA with zero idle gap, plus a 1-cycle low glitch at MID of data bit 3 of the second frame -> two data_flag pulses, values 0x55 and 0xAA (majority suppresses the glitch).
- DATA_BITS = 7, PARITY = 1: frame 0x41, then rst_n asserted mid-way through data bit 4 of a second frame -> first word 0x41 with no errors; no flag for the aborted frame; all outputs 0 after reset.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity encodings, receiver states and baud helper
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    function automatic int baud_cnt_max(input int clk_fre, input int baud);
        return clk_fre / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 3-flop rx synchronizer with falling-edge detect
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic line,
    output logic fall_edge
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rx;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign line      = s2;
    assign fall_edge = !s2 && s3;

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with majority voting and error flags
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_flag,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FRE, BAUD);
    localparam int MID          = BAUD_CNT_MAX / 2;
    localparam int CW           = $clog2(BAUD_CNT_MAX);

    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_RES  = CW'(MID + 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    if (BAUD_CNT_MAX < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $fatal(1, "uart_rx_cfg: illegal parameter combination");
    end

    rx_state_t state, state_nxt;

    logic                 line;
    logic                 fall_edge;
    logic [CW-1:0]        baud_cnt;
    logic [1:0]           samp;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ferr_acc;
    logic                 maj;
    logic                 at_wrap;
    logic                 at_res;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .line      (line),
        .fall_edge (fall_edge)
    );

    assign at_wrap = (baud_cnt == CNT_LAST);
    assign at_res  = (baud_cnt == CNT_RES);
    // Two stored samples plus the live line value form the 3-sample vote
    assign maj     = (samp[0] & samp[1]) | (samp[0] & line) | (samp[1] & line);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fall_edge) state_nxt = S_START;
            end
            S_START: begin
                if (at_res && maj) state_nxt = S_IDLE;
                else if (at_wrap)  state_nxt = S_DATA;
            end
            S_DATA: begin
                if (at_wrap && bit_cnt == LAST_DATA)
                    state_nxt = (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
            end
            S_PARITY: begin
                if (at_wrap) state_nxt = S_STOP;
            end
            S_STOP: begin
                // Final stop bit completes at resolve so an adjacent start bit is not missed
                if (at_res && bit_cnt == LAST_STOP) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt   <= '0;
            samp       <= 2'b00;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            ferr_acc   <= 1'b0;
            data       <= '0;
            data_flag  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_flag <= 1'b0;

            if (state == S_IDLE || state_nxt == S_IDLE || at_wrap) baud_cnt <= '0;
            else                                                   baud_cnt <= baud_cnt + 1'b1;

            if (baud_cnt == CNT_S0) samp[0] <= line;
            if (baud_cnt == CNT_S1) samp[1] <= line;

            case (state)
                S_START: begin
                    bit_cnt  <= '0;
                    ferr_acc <= 1'b0;
                end
                S_DATA: begin
                    if (at_res) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (at_wrap) bit_cnt <= (bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
                end
                S_PARITY: begin
                    if (at_res) par_bit <= maj;
                end
                S_STOP: begin
                    if (at_res) begin
                        if (bit_cnt == LAST_STOP) begin
                            data       <= shreg;
                            data_flag  <= 1'b1;
                            frame_err  <= ferr_acc | ~maj;
                            parity_err <= (PARITY != PAR_NONE) &&
                                          ((^shreg ^ par_bit) != (PARITY == PAR_ODD));
                        end else begin
                            ferr_acc <= ferr_acc | ~maj;
                        end
                    end else if (at_wrap) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg over four configurations
module tb_uart_rx_cfg;

    localparam int BCM  = 434;
    localparam int MIDC = 217;
    localparam int NB   [4] = '{8, 8, 8, 7};
    localparam int PARC [4] = '{0, 2, 0, 1};
    localparam int NS   [4] = '{1, 1, 2, 1};

    logic       clk = 1'b0;
    logic [3:0] rst_n = 4'b0000;
    logic [3:0] rx = 4'b1111;
    logic [3:0] flag, perr, ferr, busy;
    logic [7:0] d0, d1, d2;
    logic [6:0] d3;
    logic [8:0] dat [4];
    logic [3:0] flag_prev = 4'b0000;

    logic [12:0] rq [$];
    int total = 0;
    int bad = 0;
    int long_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FRE(50_000_000), .BAUD(115200)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .rx(rx[0]), .data(d0), .data_flag(flag[0]),
        .parity_err(perr[0]), .frame_err(ferr[0]), .busy(busy[0]));
    uart_rx_cfg #(.CLK_FRE(50_000_000), .BAUD(115200), .PARITY(2)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .rx(rx[1]), .data(d1), .data_flag(flag[1]),
        .parity_err(perr[1]), .frame_err(ferr[1]), .busy(busy[1]));
    uart_rx_cfg #(.CLK_FRE(50_000_000), .BAUD(115200), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n[2]), .rx(rx[2]), .data(d2), .data_flag(flag[2]),
        .parity_err(perr[2]), .frame_err(ferr[2]), .busy(busy[2]));
    uart_rx_cfg #(.CLK_FRE(50_000_000), .BAUD(115200), .DATA_BITS(7), .PARITY(1)) u3 (
        .clk(clk), .rst_n(rst_n[3]), .rx(rx[3]), .data(d3), .data_flag(flag[3]),
        .parity_err(perr[3]), .frame_err(ferr[3]), .busy(busy[3]));

    assign dat[0] = {1'b0, d0};
    assign dat[1] = {1'b0, d1};
    assign dat[2] = {1'b0, d2};
    assign dat[3] = {2'b00, d3};

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (flag[i]) begin
                rq.push_back({2'(i), perr[i], ferr[i], dat[i]});
                if (flag_prev[i]) long_cnt++;
            end
        end
        flag_prev = flag;
    end

    // Reference: word = first NB data bits, parity judged by total count of ones
    function automatic logic [12:0] model(input int inst, input logic [8:0] d,
                                          input logic pbit, input logic [1:0] stops);
        int         ones = 0;
        logic [8:0] m = '0;
        logic       pe, fe;
        for (int i = 0; i < NB[inst]; i++) begin
            m[i] = d[i];
            ones += int'(d[i]);
        end
        pe = (PARC[inst] != 0) && ((((ones + int'(pbit)) % 2) == 1) != (PARC[inst] == 1));
        fe = (stops[0] == 1'b0) || (NS[inst] == 2 && stops[1] == 1'b0);
        return {2'(inst), pe, fe, m};
    endfunction

    task automatic drive_bit(input int inst, input logic v, input int ncyc, input int glitch_at);
        for (int c = 0; c < ncyc; c++) begin
            rx[inst] = (c == glitch_at) ? 1'b0 : v;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int inst, input logic [8:0] d, input logic pbit,
                              input logic [1:0] stops, input int gbit);
        drive_bit(inst, 1'b0, BCM, -1);
        for (int i = 0; i < NB[inst]; i++) drive_bit(inst, d[i], BCM, (i == gbit) ? MIDC : -1);
        if (PARC[inst] != 0) drive_bit(inst, pbit, BCM, -1);
        for (int i = 0; i < NS[inst]; i++) drive_bit(inst, stops[i], BCM, -1);
        rx[inst] = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 4'b0000;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({flag[i], perr[i], ferr[i], busy[i], dat[i]} !== 13'd0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d got=%h exp=0", i,
                         {flag[i], perr[i], ferr[i], busy[i], dat[i]});
            end
        end
        rst_n = 4'b1111;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [12:0] e, g;
        rq.delete();
        long_cnt = 0;
        e = model(0, 9'h0A5, 1'b0, 2'b11);
        send_frame(0, 9'h0A5, 1'b0, 2'b11, -1);
        repeat (4) @(negedge clk);
        total++;
        if (rq.size() != 1) begin
            bad++;
            $display("FAIL basic_count got=%0d exp=1", rq.size());
        end else begin
            g = rq.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL basic_word got=%h exp=%h", g, e); end
        end
        total++;
        if (long_cnt != 0) begin bad++; $display("FAIL basic_pulse_width long=%0d exp=0", long_cnt); end
        total++;
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy[0]); end
    endtask

    task automatic test_parity;
        logic [12:0] e, g;
        logic        pb;
        for (int k = 0; k < 2; k++) begin
            rq.delete();
            pb = (k == 0) ? 1'b1 : 1'b0;
            e = model(1, 9'h03C, pb, 2'b11);
            send_frame(1, 9'h03C, pb, 2'b11, -1);
            repeat (4) @(negedge clk);
            total++;
            if (rq.size() != 1) begin
                bad++;
                $display("FAIL parity_count k=%0d got=%0d exp=1", k, rq.size());
            end else begin
                g = rq.pop_front();
                total++;
                if (g !== e) begin bad++; $display("FAIL parity_word k=%0d got=%h exp=%h", k, g, e); end
            end
        end
    endtask

    task automatic test_glitch;
        logic [12:0] e, g;
        rq.delete();
        drive_bit(0, 1'b0, 100, -1);
        rx[0] = 1'b1;
        total++;
        if (busy[0] !== 1'b1) begin bad++; $display("FAIL glitch_busy_high got=%b exp=1", busy[0]); end
        repeat (BCM - 100) @(negedge clk);
        total++;
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL glitch_busy_low got=%b exp=0", busy[0]); end
        total++;
        if (rq.size() != 0) begin bad++; $display("FAIL glitch_no_flag got=%0d exp=0", rq.size()); end
        rq.delete();
        e = model(0, 9'h05A, 1'b0, 2'b11);
        send_frame(0, 9'h05A, 1'b0, 2'b11, -1);
        repeat (4) @(negedge clk);
        total++;
        if (rq.size() != 1) begin
            bad++;
            $display("FAIL glitch_follow_count got=%0d exp=1", rq.size());
        end else begin
            g = rq.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL glitch_follow_word got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_framing;
        logic [12:0] e, g;
        int          inst;
        logic [1:0]  st;
        for (int k = 0; k < 3; k++) begin
            inst = (k == 0) ? 0 : 2;
            st   = (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b11;
            rq.delete();
            e = model(inst, 9'h081, 1'b0, st);
            send_frame(inst, 9'h081, 1'b0, st, -1);
            repeat (4) @(negedge clk);
            total++;
            if (rq.size() != 1) begin
                bad++;
                $display("FAIL frame_count k=%0d got=%0d exp=1", k, rq.size());
            end else begin
                g = rq.pop_front();
                total++;
                if (g !== e) begin bad++; $display("FAIL frame_word k=%0d got=%h exp=%h", k, g, e); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [12:0] e0, e1, g;
        rq.delete();
        long_cnt = 0;
        e0 = model(0, 9'h055, 1'b0, 2'b11);
        e1 = model(0, 9'h0AA, 1'b0, 2'b11);
        send_frame(0, 9'h055, 1'b0, 2'b11, -1);
        send_frame(0, 9'h0AA, 1'b0, 2'b11, 3);
        repeat (4) @(negedge clk);
        total++;
        if (rq.size() != 2) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=2", rq.size());
        end else begin
            g = rq.pop_front();
            total++;
            if (g !== e0) begin bad++; $display("FAIL b2b_first got=%h exp=%h", g, e0); end
            g = rq.pop_front();
            total++;
            if (g !== e1) begin bad++; $display("FAIL b2b_second got=%h exp=%h", g, e1); end
        end
        total++;
        if (long_cnt != 0) begin bad++; $display("FAIL b2b_pulse_width long=%0d exp=0", long_cnt); end
    endtask

    task automatic test_break;
        logic [12:0] e, g;
        rq.delete();
        e = model(0, 9'h000, 1'b0, 2'b00);
        drive_bit(0, 1'b0, 11 * BCM, -1);
        total++;
        if (rq.size() != 1) begin
            bad++;
            $display("FAIL break_count got=%0d exp=1", rq.size());
        end else begin
            g = rq.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL break_word got=%h exp=%h", g, e); end
        end
        total++;
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL break_idle got=%b exp=0", busy[0]); end
        rx[0] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random;
        logic [12:0] e, g;
        logic [8:0]  d;
        logic        pb;
        logic [1:0]  st;
        int          inst;
        for (int k = 0; k < 4; k++) begin
            inst = $urandom_range(0, 3);
            d    = 9'($urandom_range(0, 255));
            pb   = 1'($urandom_range(0, 1));
            st   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            rq.delete();
            e = model(inst, d, pb, st);
            send_frame(inst, d, pb, st, -1);
            repeat (4) @(negedge clk);
            total++;
            if (rq.size() != 1) begin
                bad++;
                $display("FAIL random_count k=%0d inst=%0d got=%0d exp=1", k, inst, rq.size());
            end else begin
                g = rq.pop_front();
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL random_word k=%0d inst=%0d got=%h exp=%h", k, inst, g, e);
                end
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [12:0] e, g;
        logic [8:0]  d;
        rq.delete();
        e = model(3, 9'h041, 1'b1, 2'b11);
        send_frame(3, 9'h041, 1'b1, 2'b11, -1);
        repeat (4) @(negedge clk);
        total++;
        if (rq.size() != 1) begin
            bad++;
            $display("FAIL abort_first_count got=%0d exp=1", rq.size());
        end else begin
            g = rq.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL abort_first_word got=%h exp=%h", g, e); end
        end
        d = 9'($urandom_range(0, 127));
        drive_bit(3, 1'b0, BCM, -1);
        for (int i = 0; i < 4; i++) drive_bit(3, d[i], BCM, -1);
        drive_bit(3, d[4], MIDC, -1);
        total++;
        if (busy[3] !== 1'b1) begin bad++; $display("FAIL abort_busy_mid got=%b exp=1", busy[3]); end
        rst_n[3] = 1'b0;
        #1;
        total++;
        if ({flag[3], perr[3], ferr[3], busy[3], dat[3]} !== 13'd0) begin
            bad++;
            $display("FAIL abort_outputs got=%h exp=0", {flag[3], perr[3], ferr[3], busy[3], dat[3]});
        end
        @(negedge clk);
        rx[3] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n[3] = 1'b1;
        repeat (8 * BCM) @(negedge clk);
        total++;
        if (rq.size() != 0) begin bad++; $display("FAIL abort_no_flag got=%0d exp=0", rq.size()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_parity;
        test_glitch;
        test_framing;
        test_back_to_back;
        test_break;
        test_random;
        test_reset_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
